// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/prio_enc8_3.sv
// Combinational 8-to-3 priority encoder: lowest set bit wins, valid_o when any bit is set.
module prio_enc8_3
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan upward and keep the first set bit found.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_i[i] && !valid_o) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot grant and an idle gap between grants.
// Optional hold limit with timeout pulse is built when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD must be in 1..255");
    end

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] req_rot;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             hold_expired;
    logic             rel;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;

    assign hold_expired = (hold_q == HOLD_LAST);
`else
    assign hold_expired = 1'b0;
`endif

    // Rotate requests right by ptr so the encoder's lowest index is the current priority slot.
    always_comb begin
        req_rot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_rot[i] = req[IDX_W'(i) + ptr_q];
        end
    end

    prio_enc8_3 u_enc (
        .req_i   (req_rot),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    // Undo the rotation; 3-bit addition wraps modulo 8.
    assign sel_idx = enc_idx + ptr_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        rel       = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d = GRANT;
                    idx_d   = sel_idx;
                    gnt_d   = idx_to_onehot(sel_idx);
                    valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                // done and a dropped request take precedence over the hold limit
                if (done || !req[idx_q]) begin
                    rel = 1'b1;
                end else if (hold_expired) begin
                    rel       = 1'b1;
                    timeout_d = 1'b1;
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d = hold_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (rel) begin
            state_d = IDLE;
            ptr_d   = idx_q + 1'b1;
            idx_d   = '0;
            gnt_d   = '0;
            valid_d = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Hold counter for the current owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule
